inst_loader: RTL

Boot-time instruction-memory writer for the pipelined CPU. It sits between a byte-wide host link and the write port of the instruction memory, which the CPU fetch stage only reads. It receives a framed program image as a byte stream, packs bytes big-endian into 32-bit words, and writes them to consecutive word addresses from 0. It holds the CPU in reset until a frame completes with a valid checksum.

---
 rtl/inst_loader_pkg.sv | 19 +
 rtl/word_packer.sv | 39 +++
 rtl/inst_loader.sv | 96 +++++++++
 3 files changed

// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared state encoding and framing constants for the instruction loader
package inst_loader_pkg;

    typedef enum logic [2:0] {
        SYNC,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int COUNT_W = 16;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_packer.sv
// word_packer: big-endian byte-to-word shift register with byte counter and XOR checksum
module word_packer
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  data_byte,
    output logic [31:0] word,
    output logic        word_full,
    output logic [7:0]  csum
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt;

    // shift bytes in MSB-first, count them and fold them into the checksum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
            cnt  <= '0;
            csum <= '0;
        end else if (clear) begin
            word <= '0;
            cnt  <= '0;
            csum <= '0;
        end else if (shift_en) begin
            word <= {word[23:0], data_byte};
            cnt  <= cnt + CNT_W'(1);
            csum <= csum ^ data_byte;
        end
    end

    // high when the byte being shifted now completes the word
    assign word_full = cnt == CNT_W'(BYTES_PER_WORD - 1);

endmodule

// File: rtl/inst_loader.sv
// inst_loader: receives a framed program image over a byte link and writes it into instruction memory
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t             state, next;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W:0]   idx;
    logic [COUNT_W:0]   idx_next;
    logic [COUNT_W-1:0] count_full;
    logic               count_ok;
    logic               acc;
    logic               restart;
    logic [31:0]        word;
    logic               word_full;
    logic [7:0]         csum;

    assign acc        = rx_valid && rx_ready;
    assign restart    = acc && rx_data == SYNC_BYTE && (state == SYNC || state == DONE || state == ERR);
    assign idx_next   = idx + (COUNT_W+1)'(1);
    assign count_full = {count[15:8], rx_data};
    assign count_ok   = count_full != '0 && {1'b0, count_full} <= ((COUNT_W+1)'(1) << ADDR_W);

    word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (restart),
        .shift_en  (acc && state == DATA),
        .data_byte (rx_data),
        .word      (word),
        .word_full (word_full),
        .csum      (csum)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SYNC;
        else      state <= next;
    end

    // next-state logic driven by accepted bytes and the word index
    always_comb begin
        next = state;
        case (state)
            SYNC, DONE, ERR: next = restart ? LEN_HI : state;
            LEN_HI:          next = acc ? LEN_LO : state;
            LEN_LO:          next = acc ? (count_ok ? DATA : ERR) : state;
            DATA:            next = acc && word_full ? WRITE : state;
            WRITE:           next = idx_next == {1'b0, count} ? CSUM : DATA;
            CSUM:            next = acc ? (rx_data == csum ? DONE : ERR) : state;
            default:         next = SYNC;
        endcase
    end

    // word count capture and write-address index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            idx   <= '0;
        end else begin
            if (restart)                 idx        <= '0;
            if (acc && state == LEN_HI)  count[15:8] <= rx_data;
            if (acc && state == LEN_LO)  count[7:0]  <= rx_data;
            if (state == WRITE)          idx        <= idx_next;
        end
    end

    // outputs decoded from state and registers only, never from rx inputs
    always_comb begin
        rx_ready = state != WRITE;
        im_we    = state == WRITE;
        im_addr  = idx[ADDR_W-1:0];
        im_wdata = word;
        cpu_rst  = state == DONE;
        busy     = state inside {LEN_HI, LEN_LO, DATA, WRITE, CSUM};
        done     = state == DONE;
        err      = state == ERR;
    end

endmodule
